// File: rtl/bec_serial_port_if.sv
// Operand/result link between the serial BEC port and its surroundings:
// the wrapper-side serial lines together with the parallel datapath bus.
interface bec_serial_port_if #(
  parameter int WIDTH = 163
);
  logic             load_req;
  logic             w1, z1, w2, z2, inv_w0, d;
  logic             load_data;
  logic             ena_proc;
  logic             ki;
  logic             next_key;
  logic             core_start;
  logic             core_ki;
  logic             core_step_done;
  logic [WIDTH-1:0] core_w1, core_z1, core_w2, core_z2, core_inv_w0, core_d;
  logic [WIDTH-1:0] core_wout, core_zout;
  logic             slv_done;
  logic             wout, zout;
  logic [3:0]       becStatus;

  modport slave (
    input  load_req, w1, z1, w2, z2, inv_w0, d, ena_proc, ki,
           core_step_done, core_wout, core_zout,
    output load_data, next_key, core_start, core_ki,
           core_w1, core_z1, core_w2, core_z2, core_inv_w0, core_d,
           slv_done, wout, zout, becStatus
  );

  modport master (
    output load_req, w1, z1, w2, z2, inv_w0, d, ena_proc, ki,
           core_step_done, core_wout, core_zout,
    input  load_data, next_key, core_start, core_ki,
           core_w1, core_z1, core_w2, core_z2, core_inv_w0, core_d,
           slv_done, wout, zout, becStatus
  );
endinterface

// File: rtl/bec_serial_port.sv
// Core-side end of the serial BEC link: deserialises operands, hands key bits
// to the ladder datapath one step at a time, and serialises the results back.
module bec_serial_port #(
  parameter int WIDTH = 163,
  parameter int CW    = 8
) (
  input logic              wb_clk_i,
  input logic              wb_rst_ni,
  bec_serial_port_if.slave bus
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD   = 3'd1;
  localparam logic [2:0] S_LOADED = 3'd2;
  localparam logic [2:0] S_STEP   = 3'd3;
  localparam logic [2:0] S_WAIT   = 3'd4;
  localparam logic [2:0] S_ADV    = 3'd5;
  localparam logic [2:0] S_FIN    = 3'd6;
  localparam logic [2:0] S_UNLOAD = 3'd7;

  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  logic [2:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [CW-1:0]    kcnt_q, kcnt_d;
  logic [WIDTH-1:0] w1_q, w1_d, z1_q, z1_d, w2_q, w2_d, z2_q, z2_d;
  logic [WIDTH-1:0] inv_q, inv_d, d_q, d_d;
  logic [WIDTH-1:0] shw_q, shw_d, shz_q, shz_d;
  logic             core_ki_q, core_ki_d;
  logic             core_start_q, core_start_d;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    kcnt_d       = kcnt_q;
    w1_d         = w1_q;
    z1_d         = z1_q;
    w2_d         = w2_q;
    z2_d         = z2_q;
    inv_d        = inv_q;
    d_d          = d_q;
    shw_d        = shw_q;
    shz_d        = shz_q;
    core_ki_d    = core_ki_q;
    core_start_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.load_req) begin
          state_d = S_LOAD;
          cnt_d   = '0;
        end
      end
      S_LOAD: begin
        w1_d  = {w1_q[WIDTH-2:0], bus.w1};
        z1_d  = {z1_q[WIDTH-2:0], bus.z1};
        w2_d  = {w2_q[WIDTH-2:0], bus.w2};
        z2_d  = {z2_q[WIDTH-2:0], bus.z2};
        inv_d = {inv_q[WIDTH-2:0], bus.inv_w0};
        d_d   = {d_q[WIDTH-2:0], bus.d};
        cnt_d = cnt_q + ONE;
        if (cnt_q == LAST) begin
          state_d = S_LOADED;
          cnt_d   = '0;
        end
      end
      S_LOADED: begin
        if (bus.ena_proc) begin
          state_d = S_STEP;
          kcnt_d  = '0;
        end
      end
      // Dropping ena_proc anywhere in the key loop abandons the run; the
      // operand registers are kept so the datapath view stays stable.
      S_STEP: begin
        if (!bus.ena_proc) begin
          state_d = S_IDLE;
        end else begin
          core_ki_d    = bus.ki;
          core_start_d = 1'b1;
          state_d      = S_WAIT;
        end
      end
      S_WAIT: begin
        if (!bus.ena_proc) begin
          state_d = S_IDLE;
        end else if (bus.core_step_done) begin
          state_d = S_ADV;
        end
      end
      S_ADV: begin
        if (!bus.ena_proc) begin
          state_d = S_IDLE;
        end else begin
          kcnt_d  = kcnt_q + ONE;
          state_d = (kcnt_q == LAST) ? S_FIN : S_STEP;
        end
      end
      S_FIN: begin
        shw_d   = bus.core_wout;
        shz_d   = bus.core_zout;
        cnt_d   = '0;
        state_d = S_UNLOAD;
      end
      S_UNLOAD: begin
        shw_d = {shw_q[WIDTH-2:0], 1'b0};
        shz_d = {shz_q[WIDTH-2:0], 1'b0};
        cnt_d = cnt_q + ONE;
        if (cnt_q == LAST) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      kcnt_q       <= '0;
      w1_q         <= '0;
      z1_q         <= '0;
      w2_q         <= '0;
      z2_q         <= '0;
      inv_q        <= '0;
      d_q          <= '0;
      shw_q        <= '0;
      shz_q        <= '0;
      core_ki_q    <= 1'b0;
      core_start_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      kcnt_q       <= kcnt_d;
      w1_q         <= w1_d;
      z1_q         <= z1_d;
      w2_q         <= w2_d;
      z2_q         <= z2_d;
      inv_q        <= inv_d;
      d_q          <= d_d;
      shw_q        <= shw_d;
      shz_q        <= shz_d;
      core_ki_q    <= core_ki_d;
      core_start_q <= core_start_d;
    end
  end

  // core_start and core_ki are registered together, so the datapath sees the
  // key bit valid in the same cycle as the start pulse.
  assign bus.load_data   = (state_q == S_LOAD);
  assign bus.next_key    = (state_q == S_ADV);
  assign bus.core_start  = core_start_q;
  assign bus.core_ki     = core_ki_q;
  assign bus.slv_done    = (state_q == S_FIN);
  assign bus.wout        = (state_q == S_UNLOAD) && shw_q[WIDTH-1];
  assign bus.zout        = (state_q == S_UNLOAD) && shz_q[WIDTH-1];
  assign bus.core_w1     = w1_q;
  assign bus.core_z1     = z1_q;
  assign bus.core_w2     = w2_q;
  assign bus.core_z2     = z2_q;
  assign bus.core_inv_w0 = inv_q;
  assign bus.core_d      = d_q;

  assign bus.becStatus[0] = (state_q == S_UNLOAD) && (cnt_q == LAST);
  assign bus.becStatus[1] = (state_q == S_STEP) || (state_q == S_WAIT) || (state_q == S_ADV);
  assign bus.becStatus[2] = (state_q == S_LOADED);
  assign bus.becStatus[3] = (state_q != S_IDLE);

endmodule

// File: tb/tb_bec_serial_port.sv
// Self-checking bench for bec_serial_port: plays the wrapper and a simple
// datapath around the port and compares every frame against expected streams.
module tb_bec_serial_port;

  localparam int WIDTH = 163;
  localparam int CW    = 8;

  typedef logic [WIDTH-1:0] word_t;

  typedef struct {
    word_t opW1, opZ1, opW2, opZ2, opInv, opD;
    word_t key;
    word_t resW, resZ;
    int    lat;
    int    abortAfter;
    int    resetBit;
    int    expStarts;
    int    expNextKeys;
    int    expDone;
  } frame_t;

  logic wb_clk_i  = 1'b0;
  logic wb_rst_ni = 1'b0;

  int testsRun    = 0;
  int testsFailed = 0;

  frame_t table_q[5];

  bec_serial_port_if #(.WIDTH(WIDTH)) bus ();

  bec_serial_port #(.WIDTH(WIDTH), .CW(CW)) dut (
    .wb_clk_i (wb_clk_i),
    .wb_rst_ni(wb_rst_ni),
    .bus      (bus)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  task automatic checkOutput(input string name, input word_t actual, input word_t expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  function automatic word_t randWord();
    word_t w;
    for (int i = 0; i < WIDTH; i++) w[i] = 1'($urandom_range(0, 1));
    return w;
  endfunction

  function automatic logic [16:0] outSummary();
    return {bus.load_data, bus.next_key, bus.core_start, bus.core_ki, bus.slv_done,
            bus.wout, bus.zout, bus.becStatus,
            |bus.core_w1, |bus.core_z1, |bus.core_w2, |bus.core_z2,
            |bus.core_inv_w0, |bus.core_d};
  endfunction

  task automatic randomInputs();
    bus.w1             = 1'($urandom_range(0, 1));
    bus.z1             = 1'($urandom_range(0, 1));
    bus.w2             = 1'($urandom_range(0, 1));
    bus.z2             = 1'($urandom_range(0, 1));
    bus.inv_w0         = 1'($urandom_range(0, 1));
    bus.d              = 1'($urandom_range(0, 1));
    bus.ki             = 1'($urandom_range(0, 1));
    bus.ena_proc       = 1'($urandom_range(0, 1));
    bus.core_step_done = 1'($urandom_range(0, 1));
    bus.core_wout      = randWord();
    bus.core_zout      = randWord();
  endtask

  // Plays one complete frame: the wrapper streams operands and key bits, the
  // datapath model answers each start after f.lat cycles, and the result
  // stream is compared bit by bit against the expected words.
  task automatic applyStimulus(input frame_t f, input string tag);
    int   cycles = 0, idx = 0, nk = 0, starts = 0, dones = 0, loadCycles = 0;
    int   bitIdx = -1, stepCnt = 0, postAbort = -1;
    int   kiErrs = 0, unloadErrs = 0, lastFlagErrs = 0;
    logic prevLoad = 1'b0, finished = 1'b0, postUnload = 1'b0;

    bus.ena_proc       = 1'b0;
    bus.load_req       = 1'b1;
    bus.ki             = f.key[0];
    bus.core_wout      = f.resW;
    bus.core_zout      = f.resZ;
    bus.core_step_done = 1'b0;

    while (!finished) begin
      @(negedge wb_clk_i);
      cycles++;
      if (cycles > 6000) begin
        testsRun++;
        testsFailed++;
        $display("[TB] FAIL %s timeout: got %0d cycles, required completion within 6000", tag, cycles);
        finished = 1'b1;
      end else begin
        if (postAbort >= 0) begin
          postAbort++;
          if (postAbort == 1) checkOutput({tag, " status after abort"}, word_t'(bus.becStatus), 0);
          if (postAbort == 6) finished = 1'b1;
        end

        if (postUnload) begin
          checkOutput({tag, " idle after unload"}, word_t'({bus.becStatus, bus.wout, bus.zout}), 0);
          finished = 1'b1;
        end

        if (bus.load_data) begin
          bus.load_req = 1'b0;
          bus.w1       = f.opW1[WIDTH-1-idx];
          bus.z1       = f.opZ1[WIDTH-1-idx];
          bus.w2       = f.opW2[WIDTH-1-idx];
          bus.z2       = f.opZ2[WIDTH-1-idx];
          bus.inv_w0   = f.opInv[WIDTH-1-idx];
          bus.d        = f.opD[WIDTH-1-idx];
          idx++;
          loadCycles++;
        end else begin
          bus.w1     = 1'($urandom_range(0, 1));
          bus.z1     = 1'($urandom_range(0, 1));
          bus.w2     = 1'($urandom_range(0, 1));
          bus.z2     = 1'($urandom_range(0, 1));
          bus.inv_w0 = 1'($urandom_range(0, 1));
          bus.d      = 1'($urandom_range(0, 1));
        end

        if (prevLoad && !bus.load_data) begin
          checkOutput({tag, " load cycles"}, word_t'(loadCycles), word_t'(WIDTH));
          checkOutput({tag, " status loaded"}, word_t'(bus.becStatus), word_t'(4'b1100));
          checkOutput({tag, " core_w1"}, bus.core_w1, f.opW1);
          checkOutput({tag, " core_z1"}, bus.core_z1, f.opZ1);
          checkOutput({tag, " core_w2"}, bus.core_w2, f.opW2);
          checkOutput({tag, " core_z2"}, bus.core_z2, f.opZ2);
          checkOutput({tag, " core_inv_w0"}, bus.core_inv_w0, f.opInv);
          checkOutput({tag, " core_d"}, bus.core_d, f.opD);
          bus.ena_proc = 1'b1;
        end
        prevLoad = bus.load_data;

        // load_req toggles freely during the key loop and must not re-trigger
        if (bus.becStatus[1]) bus.load_req = 1'($urandom_range(0, 1));

        if (bus.core_start) begin
          if (starts >= WIDTH || bus.core_ki !== f.key[starts] || !bus.becStatus[1]) kiErrs++;
          starts++;
          stepCnt            = f.lat;
          bus.core_step_done = 1'b0;
          if (starts == f.abortAfter + 1) begin
            bus.ena_proc = 1'b0;
            bus.load_req = 1'b0;
            postAbort    = 0;
          end
        end else if (stepCnt > 0) begin
          stepCnt--;
          bus.core_step_done = (stepCnt == 0);
        end else begin
          bus.core_step_done = 1'b0;
        end

        if (bus.next_key) begin
          nk++;
          if (nk < WIDTH) bus.ki = f.key[nk];
        end

        if (bitIdx >= 0) begin
          if (bus.wout !== f.resW[WIDTH-1-bitIdx] || bus.zout !== f.resZ[WIDTH-1-bitIdx]) unloadErrs++;
          if (bus.becStatus[0] !== (bitIdx == WIDTH - 1)) lastFlagErrs++;
          if (bitIdx == f.resetBit) begin
            wb_rst_ni = 1'b0;
            #1;
            checkOutput({tag, " async reset outputs"}, word_t'(outSummary()), 0);
            @(negedge wb_clk_i);
            wb_rst_ni = 1'b1;
            bitIdx    = -1;
            finished  = 1'b1;
          end else begin
            bitIdx++;
            if (bitIdx == WIDTH) begin
              bitIdx     = -1;
              postUnload = 1'b1;
            end
          end
        end

        if (bus.slv_done) begin
          dones++;
          bus.load_req = 1'b0;
          bitIdx       = 0;
        end
      end
    end

    bus.ena_proc       = 1'b0;
    bus.load_req       = 1'b0;
    bus.core_step_done = 1'b0;

    checkOutput({tag, " core_start count"}, word_t'(starts), word_t'(f.expStarts));
    checkOutput({tag, " next_key count"}, word_t'(nk), word_t'(f.expNextKeys));
    checkOutput({tag, " slv_done count"}, word_t'(dones), word_t'(f.expDone));
    checkOutput({tag, " core_ki errors"}, word_t'(kiErrs), 0);
    if (f.abortAfter >= 0) begin
      checkOutput({tag, " operands kept w1"}, bus.core_w1, f.opW1);
      checkOutput({tag, " operands kept d"}, bus.core_d, f.opD);
    end else begin
      checkOutput({tag, " unload bit errors"}, word_t'(unloadErrs), 0);
      checkOutput({tag, " last-bit flag errors"}, word_t'(lastFlagErrs), 0);
    end
  endtask

  initial begin
    word_t  alt;
    frame_t fr;
    logic [16:0] acc;

    for (int i = 0; i < WIDTH; i++) alt[i] = (i % 2 == 0);

    table_q[0] = '{opW1: (word_t'(5) << 160) | word_t'(1), opZ1: '1, opW2: '1, opZ2: '1,
                   opInv: '1, opD: '1, key: alt, resW: word_t'(1), resZ: word_t'(1) << 162,
                   lat: 4, abortAfter: -1, resetBit: -1,
                   expStarts: WIDTH, expNextKeys: WIDTH, expDone: 1};
    table_q[1] = '{opW1: randWord(), opZ1: randWord(), opW2: randWord(), opZ2: randWord(),
                   opInv: randWord(), opD: randWord(), key: randWord(), resW: randWord(),
                   resZ: randWord(), lat: 2, abortAfter: 10, resetBit: -1,
                   expStarts: 11, expNextKeys: 10, expDone: 0};
    table_q[2] = '{opW1: randWord(), opZ1: randWord(), opW2: randWord(), opZ2: randWord(),
                   opInv: randWord(), opD: randWord(), key: randWord(), resW: '1,
                   resZ: randWord(), lat: 1, abortAfter: -1, resetBit: 50,
                   expStarts: WIDTH, expNextKeys: WIDTH, expDone: 1};
    table_q[3] = '{opW1: randWord(), opZ1: randWord(), opW2: randWord(), opZ2: randWord(),
                   opInv: randWord(), opD: randWord(), key: randWord(), resW: randWord(),
                   resZ: randWord(), lat: 1, abortAfter: -1, resetBit: -1,
                   expStarts: WIDTH, expNextKeys: WIDTH, expDone: 1};
    table_q[4] = '{opW1: '0, opZ1: '1, opW2: '0, opZ2: '1, opInv: '0, opD: '1, key: '1,
                   resW: '1, resZ: '0, lat: 3, abortAfter: WIDTH - 1, resetBit: -1,
                   expStarts: WIDTH, expNextKeys: WIDTH - 1, expDone: 0};

    bus.load_req = 1'b0;
    randomInputs();
    for (int i = 0; i < 5; i++) begin
      @(negedge wb_clk_i);
      randomInputs();
      bus.load_req = 1'($urandom_range(0, 1));
    end
    checkOutput("reset held outputs", word_t'(outSummary()), 0);

    wb_rst_ni    = 1'b1;
    bus.load_req = 1'b0;
    acc          = '0;
    for (int i = 0; i < 20; i++) begin
      randomInputs();
      @(negedge wb_clk_i);
      acc = acc | outSummary();
    end
    checkOutput("idle outputs", word_t'(acc), 0);

    bus.ena_proc       = 1'b0;
    bus.core_step_done = 1'b0;
    @(negedge wb_clk_i);

    for (int t = 0; t < 5; t++) begin
      applyStimulus(table_q[t], $sformatf("vec%0d", t));
      repeat (2) @(negedge wb_clk_i);
    end

    for (int r = 0; r < 4; r++) begin
      fr.opW1  = randWord();
      fr.opZ1  = randWord();
      fr.opW2  = randWord();
      fr.opZ2  = randWord();
      fr.opInv = randWord();
      fr.opD   = randWord();
      fr.key   = randWord();
      fr.resW  = randWord();
      fr.resZ  = randWord();
      fr.lat   = int'($urandom_range(1, 6));
      fr.resetBit   = -1;
      fr.abortAfter = (r == 3) ? int'($urandom_range(0, WIDTH - 1)) : -1;
      if (fr.abortAfter >= 0) begin
        fr.expStarts   = fr.abortAfter + 1;
        fr.expNextKeys = fr.abortAfter;
        fr.expDone     = 0;
      end else begin
        fr.expStarts   = WIDTH;
        fr.expNextKeys = WIDTH;
        fr.expDone     = 1;
      end
      applyStimulus(fr, $sformatf("rand%0d", r));
      repeat (2) @(negedge wb_clk_i);
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/bec_serial_port.md
Name: bec_serial_port

Overview:
- Core-side end of the serial BEC operand/result link; the LA-facing wrapper is the other end.
- Deserialises six WIDTH-bit operands (w1, z1, w2, z2, inv_w0, d), MSB first, into parallel registers for the BEC datapath.
- Consumes key bits LSB first, one per ladder step, via the next_key handshake.
- Serialises the wout/zout results back MSB first, and reports progress on becStatus and slv_done.

Parameters:
- WIDTH, 163, operand width, key length and serial frame length.
- CW, 8, counter width; must satisfy 2^CW > WIDTH.

Ports:
- wb_clk_i  in  1  single clock.
- wb_rst_ni  in  1  asynchronous active-low reset.
- load_req  in  1  wrapper is ready to stream operands.
- w1, z1, w2, z2, inv_w0, d  in  1 each  serial operand bits.
- load_data  out  1  high while operand bits are being sampled.
- ena_proc  in  1  processing enable (master_ena_proc).
- ki  in  1  current key bit.
- next_key  out  1  one-cycle pulse; wrapper shifts the key right on this edge.
- core_start  out  1  one-cycle step-start pulse.
- core_ki  out  1  key bit for the current step.
- core_step_done  in  1  one-cycle pulse from the datapath.
- core_w1, core_z1, core_w2, core_z2, core_inv_w0, core_d  out  WIDTH each  parallel operands.
- core_wout, core_zout  in  WIDTH each  parallel results.
- slv_done  out  1  processing finished.
- wout, zout  out  1  serial result bits.
- becStatus  out  4  status; see Behaviour.

Behaviour:
- Reset (wb_rst_ni=0, async): state=IDLE; counters=0; all core_* operand registers=0; all outputs 0.
- FSM states: IDLE, LOAD, LOADED, STEP, WAIT, ADV, FIN, UNLOAD. All outputs are registered or decoded from state/counter only.
- IDLE:
  - load_req=1 -> LOAD, cnt=0.
  - Every other input is ignored.
- LOAD:
  - load_data=1.
  - Each cycle, every operand register shifts {reg[WIDTH-2:0], bit}.
  - cnt increments per cycle.
  - After exactly WIDTH samples (cnt==WIDTH-1 at the sampling edge) -> LOADED.
  - The first bit sampled is operand[WIDTH-1].
- LOADED:
  - becStatus[2]=1.
  - ena_proc=1 -> STEP, kcnt=0.
- STEP:
  - Latch core_ki<=ki.
  - Pulse core_start for one cycle.
  - -> WAIT.
- WAIT:
  - core_step_done=1 -> ADV.
  - ena_proc=0 in STEP/WAIT/ADV -> abort to IDLE next cycle; no further core_start or next_key; operand registers retained.
- ADV:
  - Pulse next_key for one cycle; kcnt++.
  - If kcnt was WIDTH-1 -> FIN, else -> STEP.
  - Exactly WIDTH next_key pulses per run.
- FIN:
  - slv_done=1 for exactly one cycle.
  - Capture core_wout/core_zout into the output shift registers.
  - -> UNLOAD, cnt=0.
- UNLOAD:
  - wout=shw[WIDTH-1], zout=shz[WIDTH-1].
  - Both shift left one bit per cycle for exactly WIDTH cycles.
  - The wrapper samples one bit every cycle starting the cycle after FIN.
  - becStatus[0]=1 only during the final bit cycle (cnt==WIDTH-1).
  - Then -> IDLE.
- becStatus:
  - [0]: last result bit on the line.
  - [1]: state in {STEP, WAIT, ADV}.
  - [2]: state==LOADED.
  - [3]: state!=IDLE.
- core_step_done outside WAIT is ignored.
- core_step_done coincident with ena_proc falling: the abort wins.
- load_req during any non-IDLE state is ignored; no re-trigger until back in IDLE.
- Async reset mid-LOAD/UNLOAD: immediate return to IDLE; partially shifted data is cleared.
- Latencies:
  - load_req to first sample: 1 cycle.
  - Per key bit: 3 cycles plus the datapath step latency.
  - FIN to the first result bit on wout: 1 cycle.

Test Plan:
- Reset/idle: hold wb_rst_ni=0 with random inputs, then release with load_req=0 for 20 cycles -> all outputs 0, becStatus=4'b0000.
- Load frame: w1 stream = 163'h5_0000...0001 MSB first, other operands all-ones -> core_w1=163'h5_0000...0001, others all-ones, load_data high exactly 163 cycles, becStatus[2] rises the following cycle.
- Key loop: ki pattern 1,0,1,... with a core model completing each step 4 cycles after core_start -> 163 core_start pulses, core_ki matches the pattern, 163 next_key pulses, single slv_done pulse.
- Unload: core_wout=163'h1, core_zout=1<<162 -> wout is 0 for 162 cycles then 1; zout is 1 then 162 zeros; becStatus[0] high only in cycle 163; then IDLE.
- Abort: drop ena_proc after 10 key steps -> IDLE next cycle, no slv_done, no further next_key, becStatus=0.
- Async reset pulse mid-UNLOAD (bit 50) -> outputs 0 immediately; a new load_req runs a full frame correctly.
